// File: rtl/des_key_schedule.sv
// DES round-key generator: rotates C/D from one stored K+ and applies PC-2,
// yielding K1..K16 (encrypt) or K16..K1 (decrypt). Optional DES_KS_BACKPRESSURE_EN adds subkey_ready.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:55] kplus,
`ifdef DES_KS_BACKPRESSURE_EN
  input  logic        subkey_ready,
`endif
  output logic [0:47] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic        ready;
  logic [55:0] kp;
  logic [55:0] cd;
  logic [47:0] sk;

  // PC-2 selection table, FIPS 1-based positions into C||D
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

`ifdef DES_KS_BACKPRESSURE_EN
  assign ready = subkey_ready;
`else
  assign ready = 1'b1;
`endif

  function automatic logic [1:0] shift_of(input logic [4:0] n);
    return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic [1:0] s);
    return (s == 2'd1) ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic [1:0] s);
    return (s == 2'd1) ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

  // Packed [55:0] keeps FIPS bit 1 in the MSB
  assign kp = kplus;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dec_d   = decrypt;
          round_d = 4'd0;
          // Decrypt starts at K16, whose C/D equal C0/D0 (total rotation 28)
          if (decrypt) begin
            c_d = kp[55:28];
            d_d = kp[27:0];
          end else begin
            c_d = rotl(kp[55:28], 2'd1);
            d_d = rotl(kp[27:0], 2'd1);
          end
        end
      end
      RUN: begin
        if (ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            round_d = 4'd0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            if (dec_q) begin
              c_d = rotr(c_q, shift_of(5'd16 - {1'b0, round_q}));
              d_d = rotr(d_q, shift_of(5'd16 - {1'b0, round_q}));
            end else begin
              c_d = rotl(c_q, shift_of({1'b0, round_q} + 5'd2));
              d_d = rotl(d_q, shift_of({1'b0, round_q} + 5'd2));
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign cd = {c_q, d_q};

  for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
    assign sk[47-gi] = cd[56-PC2[gi]];
  end

  assign subkey       = sk;
  assign busy         = (state_q == RUN);
  assign subkey_valid = (state_q == RUN);
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule; reference computes each Kn from
// the cumulative rotation of C0/D0 and a bit-array PC-2.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [0:55] kplus;
  logic        ready_drv;
  logic [0:47] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .kplus        (kplus),
`ifdef DES_KS_BACKPRESSURE_EN
    .subkey_ready (ready_drv),
`endif
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [47:0] ref_key(input logic [55:0] kp, input int n);
    bit cdb [1:56];
    int tot;
    logic [47:0] k;
    tot = 0;
    for (int i = 0; i < n; i++) tot += shifts[i];
    for (int p = 1; p <= 28; p++) begin
      cdb[p]    = kp[55 - ((p - 1 + tot) % 28)];
      cdb[p+28] = kp[27 - ((p - 1 + tot) % 28)];
    end
    for (int j = 0; j < 48; j++) k[47-j] = cdb[pc2[j]];
    return k;
  endfunction

  function automatic logic [47:0] exp_at(input logic [55:0] kp, input bit dec, input int pos);
    return ref_key(kp, dec ? 16 - pos : pos + 1);
  endfunction

  // Results of the last collect() run
  logic [47:0] got_key[$];
  int          got_round[$];
  logic [47:0] s_key[$];
  int          s_round[$];
  bit          s_valid[$];
  bit          s_ready[$];
  int          done_cyc;
  int          done_cnt;

  task automatic collect(input logic [55:0] kp, input bit dec, input int stall_round,
                         input int stall_len, input bit disturb, input bit rand_ready);
    int stall_left;
    int cyc;
    int after;
    got_key.delete(); got_round.delete();
    s_key.delete(); s_round.delete(); s_valid.delete(); s_ready.delete();
    done_cyc = -1;
    done_cnt = 0;
    stall_left = stall_len;
    @(negedge clk);
    kplus = kp; decrypt = dec; start = 1'b1; ready_drv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    after = 0;
    while (cyc < 120 && after < 3) begin
      cyc++;
      start = 1'b0;
      if (disturb && cyc == 4) begin
        start = 1'b1; kplus = ~kp; decrypt = ~dec;
      end
      ready_drv = 1'b1;
      if (stall_left > 0 && subkey_valid && int'(round) == stall_round) begin
        ready_drv = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        ready_drv = ($urandom_range(0, 2) != 0);
      end
      s_key.push_back(subkey); s_round.push_back(int'(round));
      s_valid.push_back(subkey_valid); s_ready.push_back(ready_drv);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0) after++;
      if (subkey_valid && ready_drv) begin
        got_key.push_back(subkey);
        got_round.push_back(int'(round));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; kplus = '0; ready_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (subkey !== 48'h0) begin tests_failed++; $display("FAIL reset_subkey got %h exp 0", subkey); end
    tests_run++;
    if (subkey_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", subkey_valid); end
    tests_run++;
    if (round !== 4'd0) begin tests_failed++; $display("FAIL reset_round got %0d exp 0", round); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset busy %b valid %b exp 0 0", busy, subkey_valid);
    end
  endtask

  task automatic test_vector(input bit dec);
    logic [55:0] kp;
    kp = 56'hF0CCAAF556678F;
    collect(kp, dec, -1, 0, 0, 0);
    tests_run++;
    if (got_key.size() != 16) begin tests_failed++; $display("FAIL vec%0d_count got %0d exp 16", dec, got_key.size()); end
    if (got_key.size() == 16) begin
      tests_run++;
      if (got_key[0] !== (dec ? 48'hCB3D8B0E17F5 : 48'h1B02EFFC7072)) begin
        tests_failed++; $display("FAIL vec%0d_first got %h", dec, got_key[0]);
      end
      tests_run++;
      if (got_key[15] !== (dec ? 48'h1B02EFFC7072 : 48'hCB3D8B0E17F5)) begin
        tests_failed++; $display("FAIL vec%0d_last got %h", dec, got_key[15]);
      end
      for (int i = 0; i < 16; i++) begin
        tests_run++;
        if (got_key[i] !== exp_at(kp, dec, i) || got_round[i] != i) begin
          tests_failed++;
          $display("FAIL vec%0d_key[%0d] got %h/r%0d exp %h/r%0d", dec, i, got_key[i], got_round[i], exp_at(kp, dec, i), i);
        end
      end
    end
    tests_run++;
    if (done_cyc != 17 || done_cnt != 1) begin
      tests_failed++; $display("FAIL vec%0d_done cyc %0d cnt %0d exp 17 1", dec, done_cyc, done_cnt);
    end
    tests_run++;
    if (busy !== 1'b0 || subkey_valid !== 1'b0) begin
      tests_failed++; $display("FAIL vec%0d_idle busy %b valid %b exp 0 0", dec, busy, subkey_valid);
    end
  endtask

  task automatic test_random;
    logic [63:0] r;
    logic [55:0] kp;
    bit dec;
    int bad;
    for (int it = 0; it < 8; it++) begin
      r = {$urandom(), $urandom()};
      kp = r[55:0];
      dec = $urandom_range(0, 1) != 0;
      collect(kp, dec, -1, 0, 0, 0);
      bad = (got_key.size() != 16) ? 1 : 0;
      for (int i = 0; i < got_key.size() && i < 16; i++)
        if (got_key[i] !== exp_at(kp, dec, i) || got_round[i] != i) bad++;
      tests_run++;
      if (bad != 0 || done_cyc != 17 || done_cnt != 1) begin
        tests_failed++;
        $display("FAIL random[%0d] kp %h dec %0d keys %0d bad %0d done_cyc %0d exp 16 0 17", it, kp, dec, got_key.size(), bad, done_cyc);
      end
    end
  endtask

  task automatic test_start_during_run;
    logic [55:0] kp;
    int bad;
    kp = 56'h123456789ABCDE;
    collect(kp, 1'b0, -1, 0, 1, 0);
    bad = 0;
    for (int i = 0; i < got_key.size() && i < 16; i++)
      if (got_key[i] !== exp_at(kp, 1'b0, i)) bad++;
    tests_run++;
    if (got_key.size() != 16 || bad != 0) begin
      tests_failed++; $display("FAIL start_in_run keys %0d bad %0d exp 16 0", got_key.size(), bad);
    end
    tests_run++;
    if (done_cyc != 17 || done_cnt != 1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL start_in_run_done cyc %0d cnt %0d busy %b exp 17 1 0", done_cyc, done_cnt, busy);
    end
  endtask

  task automatic test_const_keys;
    logic [55:0] kp;
    logic [47:0] ex;
    int bad;
    for (int v = 0; v < 2; v++) begin
      kp = (v == 0) ? 56'h0 : {56{1'b1}};
      ex = (v == 0) ? 48'h0 : 48'hFFFFFFFFFFFF;
      collect(kp, v == 1, -1, 0, 0, 0);
      bad = 0;
      foreach (got_key[i]) if (got_key[i] !== ex) bad++;
      tests_run++;
      if (got_key.size() != 16 || bad != 0 || done_cnt != 1) begin
        tests_failed++; $display("FAIL const%0d keys %0d bad %0d done_cnt %0d exp 16 0 1", v, got_key.size(), bad, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [55:0] kp;
    int n;
    int bad;
    kp = 56'hA5A5_0F0F_3C3C_96;
    @(negedge clk);
    kplus = kp; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (round != 4'd7 && n < 30) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (round !== 4'd7) begin tests_failed++; $display("FAIL midrst_reach round %0d exp 7", round); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 || subkey !== 48'h0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async valid %b busy %b round %0d subkey %h done %b exp 0 0 0 0 0", subkey_valid, busy, round, subkey, done);
    end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (done) n++; end
    tests_run++;
    if (n != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_nodone done %0d busy %b exp 0 0", n, busy); end
    collect(kp, 1'b0, -1, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < got_key.size() && i < 16; i++)
      if (got_key[i] !== exp_at(kp, 1'b0, i)) bad++;
    tests_run++;
    if (got_key.size() != 16 || bad != 0 || done_cyc != 17) begin
      tests_failed++; $display("FAIL midrst_restart keys %0d bad %0d done_cyc %0d exp 16 0 17", got_key.size(), bad, done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    logic [55:0] kp1;
    logic [55:0] kp2;
    int n;
    kp1 = 56'h0011223344556;
    kp2 = 56'hFEDCBA98765432;
    @(negedge clk);
    kplus = kp1; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done got %b exp 1", done); end
    kplus = kp2; decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || subkey_valid !== 1'b1 || round !== 4'd0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_accept busy %b valid %b round %0d done %b exp 1 1 0 0", busy, subkey_valid, round, done);
    end
    tests_run++;
    if (subkey !== ref_key(kp2, 16)) begin
      tests_failed++; $display("FAIL b2b_first got %h exp %h", subkey, ref_key(kp2, 16));
    end
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef DES_KS_BACKPRESSURE_EN
  task automatic test_backpressure;
    logic [55:0] kp;
    logic [63:0] r;
    int bad;
    int hold_bad;
    kp = 56'hF0CCAAF556678F;
    for (int it = 0; it < 3; it++) begin
      if (it > 0) begin r = {$urandom(), $urandom()}; kp = r[55:0]; end
      collect(kp, it == 2, (it == 0) ? 5 : -1, (it == 0) ? 3 : 0, 0, it != 0);
      bad = 0;
      for (int i = 0; i < got_key.size() && i < 16; i++)
        if (got_key[i] !== exp_at(kp, it == 2, i) || got_round[i] != i) bad++;
      hold_bad = 0;
      for (int c = 0; c + 1 < s_key.size(); c++)
        if (s_valid[c] && !s_ready[c] &&
            (!s_valid[c+1] || s_key[c+1] !== s_key[c] || s_round[c+1] != s_round[c])) hold_bad++;
      tests_run++;
      if (got_key.size() != 16 || bad != 0) begin
        tests_failed++; $display("FAIL bp%0d_seq keys %0d bad %0d exp 16 0", it, got_key.size(), bad);
      end
      tests_run++;
      if (hold_bad != 0) begin tests_failed++; $display("FAIL bp%0d_hold unstable %0d exp 0", it, hold_bad); end
      tests_run++;
      if (done_cnt != 1 || (it == 0 && done_cyc != 20)) begin
        tests_failed++; $display("FAIL bp%0d_done cyc %0d cnt %0d exp 20 1", it, done_cyc, done_cnt);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector(1'b0);
    test_vector(1'b1);
    test_random();
    test_start_during_run();
    test_const_keys();
    test_reset_mid();
    test_back_to_back();
`ifdef DES_KS_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
